// File: rtl/timer_pkg.sv
// Shared types for the countdown timer bank: channel state encoding and run modes.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: strobes tick for one clk cycle every PRESCALE cycles.
module tick_prescaler #(
  parameter int PRESCALE = 192
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LP_TOP = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc_cnt;

  // Count down to zero and wrap back to the top value.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc_cnt <= LP_TOP;
    end else if (r_presc_cnt == '0) begin
      r_presc_cnt <= LP_TOP;
    end else begin
      r_presc_cnt <= r_presc_cnt - PW'(1);
    end
  end

  // Strobe is decoded straight from the register, so it is glitch-free and one cycle wide.
  assign tick = (r_presc_cnt == '0);

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of independent countdown timers sharing one prescaler tick.
// Each channel supports one-shot or auto-reload operation, pause and cancel.
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int W        = 10,
  parameter int PRESCALE = 192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   start,
  input  logic [N_CH-1:0]   cancel,
  input  logic [N_CH-1:0]   pause,
  input  logic [N_CH-1:0]   mode,
  input  logic [N_CH*W-1:0] load_value,
  output logic [N_CH*W-1:0] count,
  output logic [N_CH-1:0]   running,
  output logic [N_CH-1:0]   expired,
  output logic [N_CH-1:0]   done,
  output logic              tick
);

  logic w_tick;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign tick = w_tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_count, w_count_nxt;
    logic [W-1:0]   r_reload, w_reload_nxt;
    logic           r_mode, w_mode_nxt;
    logic           r_done, w_done_nxt;
    logic [W-1:0]   w_load;

    assign w_load = load_value[g*W +: W];

    // Next-state logic with priority cancel > start > pause > tick.
    always_comb begin
      // NOTE: every output gets a default first so no path leaves a signal unassigned (no latches).
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload;
      w_mode_nxt   = r_mode;
      w_done_nxt   = 1'b0;

      if (cancel[g]) begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end else if (start[g]) begin
        w_count_nxt  = w_load;
        w_reload_nxt = w_load;
        w_mode_nxt   = mode[g];
        if (w_load == '0) begin
          w_state_nxt = EXPIRED;
          w_done_nxt  = 1'b1;
        end else if (pause[g]) begin
          w_state_nxt = PAUSED;
        end else begin
          w_state_nxt = RUN;
        end
      end else begin
        case (r_state)
          RUN: begin
            if (pause[g]) begin
              w_state_nxt = PAUSED;
            end else if (w_tick) begin
              if (r_count > W'(1)) begin
                w_count_nxt = r_count - W'(1);
              end else if (r_count == W'(1)) begin
                w_done_nxt = 1'b1;
                if (r_mode == MODE_RELOAD) begin
                  w_count_nxt = r_reload;
                end else begin
                  w_count_nxt = '0;
                  w_state_nxt = EXPIRED;
                end
              end
            end
          end
          PAUSED: begin
            // Ticks arriving while paused are dropped, including on the release edge.
            if (!pause[g]) begin
              w_state_nxt = RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end

    // Channel register bank; done lines up with the cycle count shows 0 or the reload value.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state  <= IDLE;
        r_count  <= '0;
        r_reload <= '0;
        r_mode   <= MODE_ONESHOT;
        r_done   <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_count  <= w_count_nxt;
        r_reload <= w_reload_nxt;
        r_mode   <= w_mode_nxt;
        r_done   <= w_done_nxt;
      end
    end

    assign count[g*W +: W] = r_count;
    assign running[g]      = (r_state == RUN) || (r_state == PAUSED);
    assign expired[g]      = (r_state == EXPIRED);
    assign done[g]         = r_done;
  end

endmodule
